// File: rtl/output_slice_scheduler_pkg.sv
// Shared word width, FSM encoding and sideband flag layout for the slice scheduler.
// Pure declarations: no latency, no backpressure.
package output_slice_scheduler_pkg;

  localparam int WORD_W       = 168;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } flags_t;

  function automatic int unsigned words_for_width(int unsigned width);
    return (width + PIX_PER_WORD - 1) / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/output_slice_scheduler_if.sv
// Slice input buses plus the raster output stream of the slice scheduler.
// Latency and backpressure are defined by the module that drives the master side.
interface output_slice_scheduler_if #(
  parameter int MAX_SLICES = 4
);

  logic [MAX_SLICES-1:0]                                     in_valid;
  logic [MAX_SLICES*output_slice_scheduler_pkg::WORD_W-1:0]  in_data;
  logic [MAX_SLICES-1:0]                                     in_ready;
  logic                                                      out_valid;
  logic [output_slice_scheduler_pkg::WORD_W-1:0]             out_data;
  logic                                                      out_ready;
  logic                                                      out_sof;
  logic                                                      out_eol;
  logic                                                      out_eof;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof
  );

endinterface

// File: rtl/output_slice_scheduler_out_skid_reg.sv
// Registered valid/ready output stage carrying a data word plus sof/eol/eof flags.
// Latency 1 cycle; accepts when empty or being drained, flush empties it next cycle.
module out_skid_reg
  import output_slice_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [WORD_W-1:0] in_dat,
  input  flags_t            in_flags,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [WORD_W-1:0] out_dat,
  output flags_t            out_flags,
  input  logic              out_rdy
);

  assign in_rdy = out_rdy | ~out_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_flags <= '0;
    end else if (flush) begin
      out_vld   <= 1'b0;
      out_flags <= '0;
    end else if (in_rdy) begin
      out_vld   <= in_vld;
      out_flags <= in_vld ? in_flags : '0;
    end
  end

  // Data path carries no reset: it is only observed while out_vld is high.
  always_ff @(posedge clk) begin
    if (in_rdy && in_vld && !flush) begin
      out_dat <= in_dat;
    end
  end

endmodule

// File: rtl/output_slice_scheduler.sv
// Merges per-slice output buffers into one raster stream, slice by slice within each line.
// Latency 1 cycle; only the current slice sees in_ready, gated by output-stage space.
module output_slice_scheduler
  import output_slice_scheduler_pkg::*;
#(
  parameter int MAX_SLICE_WIDTH = 2560,
  parameter int MAX_SLICES      = 4,
  parameter int MAX_PIC_HEIGHT  = 2160
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sof,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
  input  logic [$clog2(MAX_SLICES):0]        slices_per_line,
  input  logic [$clog2(MAX_PIC_HEIGHT):0]    pic_height,
  output_slice_scheduler_if.master           bus
);

  localparam int WW  = $clog2(MAX_SLICE_WIDTH);
  localparam int SPW = $clog2(MAX_SLICES) + 1;
  localparam int PHW = $clog2(MAX_PIC_HEIGHT) + 1;

  state_t           state_q, state_d;
  logic [WW-1:0]    wps_q;
  logic [SPW-1:0]   spl_q;
  logic [PHW-1:0]   ph_q;
  logic [SPW-1:0]   slice_idx_q, slice_idx_d;
  logic [WW-1:0]    word_cnt_q, word_cnt_d;
  logic [PHW-1:0]   line_cnt_q, line_cnt_d;
  logic             first_q, first_d;

  logic                  sel_vld;
  logic [WORD_W-1:0]     sel_dat;
  logic [MAX_SLICES-1:0] in_ready_d;
  logic                  skid_rdy;
  logic                  grant;
  logic                  xfer;
  logic                  last_word, last_slice, last_line;
  flags_t                cur_flags, out_flags;

  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    for (int s = 0; s < MAX_SLICES; s++) begin
      if (slice_idx_q == SPW'(s)) begin
        sel_vld = bus.in_valid[s];
        sel_dat = bus.in_data[s*WORD_W +: WORD_W];
      end
    end
  end

  // sof wins over a coincident transfer, so the grant is withheld that cycle.
  assign grant = (state_q == ST_RUN) && !sof && skid_rdy;
  assign xfer  = grant && sel_vld;

  always_comb begin
    in_ready_d = '0;
    for (int s = 0; s < MAX_SLICES; s++) begin
      in_ready_d[s] = grant && (slice_idx_q == SPW'(s));
    end
  end

  assign bus.in_ready = in_ready_d;

  assign last_word  = (word_cnt_q == wps_q - WW'(1));
  assign last_slice = (slice_idx_q == spl_q - SPW'(1));
  assign last_line  = (line_cnt_q == ph_q - PHW'(1));

  assign cur_flags.sof = first_q;
  assign cur_flags.eol = last_word && last_slice;
  assign cur_flags.eof = last_word && last_slice && last_line;

  always_comb begin
    state_d     = state_q;
    slice_idx_d = slice_idx_q;
    word_cnt_d  = word_cnt_q;
    line_cnt_d  = line_cnt_q;
    first_d     = first_q;
    if (sof) begin
      state_d     = ST_RUN;
      slice_idx_d = '0;
      word_cnt_d  = '0;
      line_cnt_d  = '0;
      first_d     = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (xfer) begin
            first_d = 1'b0;
            if (last_word) begin
              word_cnt_d = '0;
              if (last_slice) begin
                slice_idx_d = '0;
                line_cnt_d  = line_cnt_q + PHW'(1);
                if (last_line) begin
                  state_d = ST_DONE;
                end
              end else begin
                slice_idx_d = slice_idx_q + SPW'(1);
              end
            end else begin
              word_cnt_d = word_cnt_q + WW'(1);
            end
          end
        end
        ST_DONE: begin
          // The eof word sits in the output stage until downstream takes it.
          if (!bus.out_valid || bus.out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_idx_q <= '0;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      first_q     <= 1'b0;
    end else begin
      slice_idx_q <= slice_idx_d;
      word_cnt_q  <= word_cnt_d;
      line_cnt_q  <= line_cnt_d;
      first_q     <= first_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wps_q <= '0;
      spl_q <= '0;
      ph_q  <= '0;
    end else if (sof) begin
      wps_q <= WW'(words_for_width(32'(slice_width)));
      spl_q <= slices_per_line;
      ph_q  <= pic_height;
    end
  end

  out_skid_reg u_out_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (sof),
    .in_vld    (xfer),
    .in_dat    (sel_dat),
    .in_flags  (cur_flags),
    .in_rdy    (skid_rdy),
    .out_vld   (bus.out_valid),
    .out_dat   (bus.out_data),
    .out_flags (out_flags),
    .out_rdy   (bus.out_ready)
  );

  assign bus.out_sof = out_flags.sof;
  assign bus.out_eol = out_flags.eol;
  assign bus.out_eof = out_flags.eof;

endmodule

// File: tb/tb_output_slice_scheduler.sv
// Directed bench for output_slice_scheduler: a raster-order reference model checked every cycle,
// plus literal pins on word counts and flag positions for each scenario.
module tb_output_slice_scheduler;
  import output_slice_scheduler_pkg::*;

  localparam int NS  = 4;
  localparam int SWW = $clog2(2560);
  localparam int SPW = $clog2(NS) + 1;
  localparam int PHW = $clog2(2160) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sof = 1'b0;
  logic [SWW-1:0] slice_width = '0;
  logic [SPW-1:0] slices_per_line = '0;
  logic [PHW-1:0] pic_height = '0;

  output_slice_scheduler_if #(.MAX_SLICES(NS)) bus ();

  output_slice_scheduler #(
    .MAX_SLICE_WIDTH (2560),
    .MAX_SLICES      (NS),
    .MAX_PIC_HEIGHT  (2160)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sof             (sof),
    .slice_width     (slice_width),
    .slices_per_line (slices_per_line),
    .pic_height      (pic_height),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WORD_W-1:0] d;
    logic [2:0]        f;
  } exp_t;

  exp_t expq[$];
  int   eol_pos[$];
  int   checks = 0, errors = 0;
  int   m_wps = 1, m_spl = 1, m_total = 0, acc_idx = 0, out_count = 0;
  int   eof_pos = 0, sof_pos = 0;
  int   seq[NS];
  int   cur_lim = 0, cyc = 0;
  logic [NS-1:0] en_mask = '0, hs_q = '0;
  bit   gate0 = 0, tog = 0, chk_en = 0;

  logic              prev_hs = 0, prev_stall = 0, prev_sof = 0, c_mvalid;
  logic [WORD_W-1:0] prev_acc, prev_dat;
  logic [2:0]        prev_flags;
  logic [NS-1:0]     c_exp_rdy, c_hs;
  exp_t              c_e;

  function automatic logic [WORD_W-1:0] gen(int s, int q);
    logic [31:0] m;
    m = 32'(q * 7 + s * 13) ^ 32'h5A5A_0000;
    return {8'(s + 1), 32'(q), m, ~m, m + 32'd1, m ^ 32'hFFFF_0000};
  endfunction

  task automatic check(string name, logic [WORD_W-1:0] act, logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int eolp(int i);
    if (i < eol_pos.size()) return eol_pos[i];
    return -1;
  endfunction

  // Expected stream: raster order, each line visits slices 0..spl-1, each slice gives wps words.
  task automatic build_model();
    exp_t e;
    m_wps = (int'(slice_width) + 3) / 4;
    m_spl = int'(slices_per_line);
    m_total = m_wps * m_spl * int'(pic_height);
    expq.delete();
    eol_pos.delete();
    acc_idx = 0; out_count = 0; eof_pos = 0; sof_pos = 0;
    for (int l = 0; l < int'(pic_height); l++)
      for (int s = 0; s < m_spl; s++)
        for (int w = 0; w < m_wps; w++) begin
          e.d = gen(s, l * m_wps + w);
          e.f[2] = (l == 0 && s == 0 && w == 0);
          e.f[1] = (s == m_spl - 1 && w == m_wps - 1);
          e.f[0] = e.f[1] && (l == int'(pic_height) - 1);
          expq.push_back(e);
        end
  endtask

  always @(negedge clk) begin
    if (!rst_n || !chk_en) begin
      prev_hs = 0; prev_stall = 0; prev_sof = 0; hs_q = '0;
    end else begin
      c_mvalid = (acc_idx > out_count);
      c_exp_rdy = '0;
      if (acc_idx < m_total && !sof && (!c_mvalid || bus.out_ready))
        c_exp_rdy[(acc_idx / m_wps) % m_spl] = 1'b1;
      check("in_ready", bus.in_ready, c_exp_rdy);
      check("out_valid", bus.out_valid, c_mvalid);
      if (prev_sof) check("valid_after_sof", bus.out_valid, 0);
      if (prev_hs) check("lat1_data", bus.out_data, prev_acc);
      if (prev_stall) begin
        check("stall_data", bus.out_data, prev_dat);
        check("stall_flags", {bus.out_sof, bus.out_eol, bus.out_eof}, prev_flags);
      end
      if (c_mvalid && bus.out_ready) begin
        out_count++;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word: got word %0d expected none", out_count);
        end else begin
          c_e = expq.pop_front();
          check("out_data", bus.out_data, c_e.d);
          check("out_flags", {bus.out_sof, bus.out_eol, bus.out_eof}, c_e.f);
        end
        if (bus.out_eol) eol_pos.push_back(out_count);
        if (bus.out_eof) eof_pos = out_count;
        if (bus.out_sof) sof_pos = out_count;
      end
      c_hs = bus.in_valid & bus.in_ready;
      hs_q = c_hs;
      prev_hs = (c_hs != '0);
      if (prev_hs) begin
        acc_idx++;
        for (int s = 0; s < NS; s++)
          if (c_hs[s]) prev_acc = bus.in_data[s*WORD_W +: WORD_W];
      end
      prev_stall = bus.out_valid && !bus.out_ready && !sof;
      prev_dat = bus.out_data;
      prev_flags = {bus.out_sof, bus.out_eol, bus.out_eof};
      prev_sof = sof;
      if (sof) build_model();
    end
  end

  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      bus.in_valid[s] = en_mask[s] && (seq[s] < cur_lim) && (!(gate0 && s == 0) || (cyc % 2 == 0));
      bus.in_data[s*WORD_W +: WORD_W] = gen(s, seq[s]);
    end
    bus.out_ready = tog ? cyc[0] : 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) if (hs_q[s]) seq[s]++;
    cyc++;
    drive();
  endtask

  task automatic start_frame(int w, int n, int h);
    slice_width = SWW'(w);
    slices_per_line = SPW'(n);
    pic_height = PHW'(h);
    cur_lim = ((w + 3) / 4) * h;
    for (int s = 0; s < NS; s++) seq[s] = 0;
    sof = 1'b1;
    drive();
    step();
    sof = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (expq.size() != 0 && n < 400) begin
      step();
      n++;
    end
    pin({name, "_timeout_left"}, expq.size(), 0);
    step();
    step();
  endtask

  initial begin
    for (int s = 0; s < NS; s++) seq[s] = 0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_flags", {bus.out_sof, bus.out_eol, bus.out_eof}, 0);
    check("rst_in_ready", bus.in_ready, 0);
    #10 rst_n = 1'b1;
    chk_en = 1;
    en_mask = 4'b1111;
    step();

    start_frame(16, 2, 2);
    wait_done("basic");
    pin("basic_count", out_count, 16);
    pin("basic_eol0", eolp(0), 8);
    pin("basic_eol1", eolp(1), 16);
    pin("basic_eol_n", eol_pos.size(), 2);
    pin("basic_eof", eof_pos, 16);
    pin("basic_sof", sof_pos, 1);

    start_frame(18, 1, 1);
    wait_done("w18");
    pin("w18_count", out_count, 5);
    pin("w18_eol", eolp(0), 5);
    pin("w18_eof", eof_pos, 5);

    tog = 1;
    start_frame(16, 2, 2);
    wait_done("toggle");
    pin("toggle_count", out_count, 16);
    pin("toggle_eol1", eolp(1), 16);
    tog = 0;

    gate0 = 1;
    start_frame(16, 2, 1);
    wait_done("order");
    pin("order_count", out_count, 8);
    gate0 = 0;

    start_frame(12, 4, 2);
    wait_done("four");
    pin("four_count", out_count, 24);
    pin("four_eol0", eolp(0), 12);

    start_frame(16, 2, 1);
    for (int n = 0; n < 50 && out_count < 3; n++) step();
    pin("abort_pre", out_count, 3);
    start_frame(16, 2, 1);
    wait_done("abort");
    pin("abort_count", out_count, 8);
    pin("abort_sof", sof_pos, 1);
    pin("abort_eof", eof_pos, 8);

    start_frame(16, 2, 2);
    for (int n = 0; n < 5; n++) step();
    #2;
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_flags", {bus.out_sof, bus.out_eol, bus.out_eof}, 0);
    check("arst_in_ready", bus.in_ready, 0);
    expq.delete();
    m_total = 0; acc_idx = 0; out_count = 0;
    for (int s = 0; s < NS; s++) seq[s] = 0;
    step();
    step();
    rst_n = 1'b1;
    chk_en = 1;
    for (int n = 0; n < 10; n++) step();
    pin("post_rst_count", out_count, 0);
    start_frame(8, 2, 1);
    wait_done("recover");
    pin("recover_count", out_count, 4);
    pin("recover_eof", eof_pos, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
